// File: rtl/hdmi_pll_rst_ctrl.sv
// HDMI PLL reset/lock controller: pulses the PLL reset, qualifies lock, retries on timeout
// and releases the HDMI pipeline reset. Define HDMI_PLL_LOSS_CNT_EN to add lock_loss_cnt.
module hdmi_pll_rst_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7,
    parameter int CNT_W         = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
`ifdef HDMI_PLL_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    logic             sync1_q, sync2_q;
    logic             lk_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    assign lk_s = sync2_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        unique case (state_q)
            S_RESET_PLL: begin
                if (timer_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_WAIT_LOCK: begin
                // Lock on the final timeout cycle wins over the timeout.
                if (lk_s) begin
                    state_d = S_STABILIZE;
                    timer_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    if (retry_q != RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                    end
                    timer_d = '0;
                    state_d = (retry_d == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_STABILIZE: begin
                if (!lk_s) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_RUN: begin
                if (!lk_s) begin
                    state_d = S_RESET_PLL;
                    timer_d = '0;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET_PLL;
                timer_d = '0;
            end
        endcase
        if (relock_req) begin
            state_d = S_RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    assign pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    assign sys_rst_d = (state_d != S_RUN);
    assign ready_d   = (state_d == S_RUN);
    assign fail_d    = (state_d == S_FAIL);

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= S_RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            sync1_q   <= pll_locked;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

`ifdef HDMI_PLL_LOSS_CNT_EN
    logic [7:0] loss_q, loss_d;
    logic       loss_evt;

    // Only a lock drop in RUN counts; a concurrent relock_req owns the transition.
    assign loss_evt = (state_q == S_RUN) && !lk_s && !relock_req;
    assign loss_d   = (loss_evt && (loss_q != 8'hFF)) ? loss_q + 8'd1 : loss_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_hdmi_pll_rst_ctrl.sv
// Directed bench for hdmi_pll_rst_ctrl with short timing parameters.
module tb_hdmi_pll_rst_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;
    localparam int CNT_W         = 20;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
`ifdef HDMI_PLL_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_asrt = 0;
    int n_fail = 0;

    always #10 refclk = ~refclk;

    hdmi_pll_rst_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
`ifdef HDMI_PLL_LOSS_CNT_EN
        .lock_loss_cnt(lock_loss_cnt),
`endif
        .retry_cnt (retry_cnt)
    );

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for 3 cycles
        step(3);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst", sys_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry", retry_cnt, 0);
`ifdef HDMI_PLL_LOSS_CNT_EN
        chk("rst_loss", lock_loss_cnt, 0);
`endif
        rst = 1'b0;

        // First pulse: 4 cycles after release
        step(3);
        chk("pulse1_high", pll_rst, 1);
        step(1);
        chk("pulse1_low", pll_rst, 0);
        chk("wait_sys_rst", sys_rst, 1);

        // First timeout: 100 cycles in WAIT_LOCK
        step(99);
        chk("to1_before_pll", pll_rst, 0);
        chk("to1_before_retry", retry_cnt, 0);
        step(1);
        chk("to1_pll", pll_rst, 1);
        chk("to1_retry", retry_cnt, 1);
        chk("to1_fail", fail, 0);
        step(3);
        chk("pulse2_high", pll_rst, 1);
        step(1);
        chk("pulse2_low", pll_rst, 0);

        // Second timeout reaches MAX_RETRY -> FAIL
        step(99);
        chk("to2_before_fail", fail, 0);
        step(1);
        chk("to2_fail", fail, 1);
        chk("to2_retry", retry_cnt, 2);
        chk("to2_pll", pll_rst, 1);
        chk("to2_sys_rst", sys_rst, 1);
        step(50);
        chk("fail_hold", fail, 1);
        chk("fail_hold_pll", pll_rst, 1);
        chk("fail_hold_retry", retry_cnt, 2);

        // relock_req out of FAIL
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk("relock_fail", fail, 0);
        chk("relock_retry", retry_cnt, 0);
        chk("relock_pll", pll_rst, 1);
        step(3);
        chk("relock_pulse_high", pll_rst, 1);
        step(1);
        chk("relock_pulse_low", pll_rst, 0);

        // Lock: 2 sync + 8 stable + 1 cycles to RUN
        pll_locked = 1'b1;
        step(10);
        chk("lock_ready_early", ready, 0);
        chk("lock_sys_early", sys_rst, 1);
        step(1);
        chk("lock_ready", ready, 1);
        chk("lock_sys_rst", sys_rst, 0);
        chk("lock_pll", pll_rst, 0);

        // Lock loss in RUN: reaction 3 cycles after the input edge
        pll_locked = 1'b0;
        step(2);
        chk("loss_ready_still", ready, 1);
        step(1);
        chk("loss_ready", ready, 0);
        chk("loss_sys_rst", sys_rst, 1);
        chk("loss_pll", pll_rst, 1);
`ifdef HDMI_PLL_LOSS_CNT_EN
        chk("loss_cnt1", lock_loss_cnt, 1);
`endif
        step(3);
        chk("loss_pulse_high", pll_rst, 1);
        step(1);
        chk("loss_pulse_low", pll_rst, 0);

        // One-cycle lock glitch at stable count 5
        pll_locked = 1'b1;
        step(6);
        chk("glitch_ready_pre", ready, 0);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(4);
        chk("glitch_ready_delayed", ready, 0);
        chk("glitch_retry", retry_cnt, 0);
        chk("glitch_pll", pll_rst, 0);
        step(6);
        chk("glitch_ready_late", ready, 0);
        step(1);
        chk("glitch_ready", ready, 1);

        // Drop lock, take one timeout, then relock_req on the next timeout cycle
        pll_locked = 1'b0;
        step(3);
        chk("drop2_pll", pll_rst, 1);
`ifdef HDMI_PLL_LOSS_CNT_EN
        chk("loss_cnt2", lock_loss_cnt, 2);
`endif
        step(104);
        chk("to3_retry", retry_cnt, 1);
        chk("to3_pll", pll_rst, 1);
        step(4);
        chk("to3_pulse_low", pll_rst, 0);
        step(99);
        chk("pre_collide_retry", retry_cnt, 1);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk("collide_retry", retry_cnt, 0);
        chk("collide_pll", pll_rst, 1);
        chk("collide_fail", fail, 0);
        step(3);
        chk("collide_pulse_high", pll_rst, 1);
        step(1);
        chk("collide_pulse_low", pll_rst, 0);

        // Lock seen on the exact timeout cycle counts as lock
        step(97);
        pll_locked = 1'b1;
        step(3);
        chk("edge_lock_retry", retry_cnt, 0);
        chk("edge_lock_pll", pll_rst, 0);
        step(7);
        chk("edge_lock_ready_early", ready, 0);
        step(1);
        chk("edge_lock_ready", ready, 1);

        // rst together with relock_req
        rst = 1'b1;
        relock_req = 1'b1;
        step(1);
        chk("rst_win_pll", pll_rst, 1);
        chk("rst_win_ready", ready, 0);
        chk("rst_win_sys", sys_rst, 1);
`ifdef HDMI_PLL_LOSS_CNT_EN
        chk("rst_win_loss", lock_loss_cnt, 0);
`endif
        rst = 1'b0;
        relock_req = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_pll_rst_ctrl.md
Name: hdmi_pll_rst_ctrl

Overview:
- Controller on the far side of the HDMI PLL's rst/locked interface.
- Runs on the 50 MHz reference clock and drives the PLL reset pulse.
- Synchronises and qualifies the PLL lock indication, retries on lock timeout, and releases a clean reset to the 74.25/148.5 MHz HDMI pipeline only after lock has been stable.
- Instantiated beside the PLL in the HDMI top level.

Parameters:
- RST_CYCLES, 16: width of the pll_rst pulse, in refclk cycles (≥1).
- LOCK_TIMEOUT, 500000: cycles allowed in WAIT_LOCK before a retry (10 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive cycles of synchronised lock required before release.
- MAX_RETRY, 7: number of timeouts that triggers FAIL (1..15).
- CNT_W, 20: width of the shared cycle timer; must satisfy 2^CNT_W > max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES).

Ports:
- refclk, in, 1: 50 MHz reference clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- pll_locked, in, 1: PLL locked output; asynchronous to refclk.
- relock_req, in, 1: one-cycle request to restart the PLL sequence.
- pll_rst, out, 1: drives PLL rst.
- sys_rst, out, 1: active-high reset for the HDMI pipeline.
- ready, out, 1: high in RUN.
- fail, out, 1: high in FAIL.
- retry_cnt, out, 4: lock timeouts since the last clear.

Behaviour:
- The single clock is refclk; reset rst is synchronous and active-high.
- pll_locked passes through a 2-flop synchroniser to give lk_s. Latency is 2 cycles; the synchroniser clears to 0 on rst.
- All outputs are registered.
- Reset values: state=RESET_PLL, timer=0, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0.
- State RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - Timer counts 0..RST_CYCLES-1; pll_rst is high exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK with timer=0.
- State WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If lk_s=1: go to STABILIZE, timer=0.
  - Else if timer==LOCK_TIMEOUT-1: retry_cnt+1. If the new value equals MAX_RETRY, go to FAIL; else go to RESET_PLL.
  - Otherwise timer+1.
- State STABILIZE:
  - sys_rst=1.
  - If lk_s=0: return to WAIT_LOCK, timer=0. The timeout restarts and no retry is counted.
  - If lk_s=1 for STABLE_CYCLES consecutive cycles (timer==STABLE_CYCLES-1): go to RUN and clear retry_cnt.
- State RUN:
  - sys_rst=0, ready=1.
  - If lk_s=0: go to RESET_PLL. sys_rst=1 and ready=0 from the very next registered cycle.
- State FAIL:
  - pll_rst=1 (PLL held in reset), sys_rst=1, fail=1.
  - Stays in FAIL until rst or relock_req.
- relock_req:
  - Priority over every other event in every state.
  - Next state is RESET_PLL with timer=0 and retry_cnt=0; sys_rst=1, ready=0, fail=0 next cycle.
  - relock_req in RESET_PLL restarts the pulse, lengthening pll_rst.
- Simultaneous events:
  - rst beats relock_req.
  - Lock arriving on the exact timeout cycle counts as lock, not timeout.
- retry_cnt never exceeds MAX_RETRY.
- The timer never wraps; it is reset on every state change.

Optional Feature:
- Macro: HDMI_PLL_LOSS_CNT_EN.
- Defined:
  - Adds output port lock_loss_cnt[7:0].
  - It increments on each RUN→RESET_PLL transition caused by lk_s=0, and saturates at 255.
  - Cleared only by rst; relock_req does not clear it.
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan (bench parameters RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRY=2):
- rst for 3 cycles, pll_locked=1 from cycle 10 -> pll_rst high exactly 4 cycles after rst release. ready rises 2 (sync) + 8 (stable) + 1 cycles after lock is seen in WAIT_LOCK. sys_rst falls the same cycle.
- pll_locked held 0 -> pll_rst re-pulses 104 cycles later and retry_cnt=1. After the second timeout: retry_cnt=2, fail=1, pll_rst stays 1 indefinitely.
- In FAIL, pulse relock_req -> next cycle fail=0, retry_cnt=0, pll_rst=1 for 4 cycles. Then lock at 1 -> ready=1.
- In STABILIZE, drop pll_locked for 1 cycle at stable count 5 -> state returns to WAIT_LOCK, no retry counted, ready delayed by a full new 8-cycle window.
- In RUN, drop pll_locked -> sys_rst=1 and ready=0 exactly 3 cycles after the input edge (2 sync + 1). pll_rst pulses 4 cycles. With HDMI_PLL_LOSS_CNT_EN, lock_loss_cnt goes 0→1.
- relock_req and lock timeout on the same cycle -> RESET_PLL with retry_cnt=0, not incremented.
